// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the boot-time instruction memory loader
package imem_loader_pkg;
  localparam int IMEM_DEPTH_WORDS = 256;
  localparam int XLEN_WIDTH = 32;
  typedef enum logic [1:0] {LOAD_LEN, LOAD_DATA, LOAD_SUM, DONE} loader_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: UART byte input, restart, memory write port and status outputs of the loader
//   master: loader side (consumes rx/restart, drives memory port and status)
//   slave : system side (drives rx/restart, observes memory port and status)
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS
);
  localparam int WL = $clog2(DEPTH_WORDS) + 1;
  logic                  restart;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  mem_we;
  logic [XLEN_WIDTH-1:0] mem_addr;
  logic [XLEN_WIDTH-1:0] mem_wdata;
  logic                  mem_sel;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_error;
  logic [WL-1:0]         words_loaded;
  modport master (
    input  restart, rx_valid, rx_data,
    output mem_we, mem_addr, mem_wdata, mem_sel, cpu_hold, load_done, load_error, words_loaded
  );
  modport slave (
    output restart, rx_valid, rx_data,
    input  mem_we, mem_addr, mem_wdata, mem_sel, cpu_hold, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles 4 bytes little-endian into a 32-bit word
//   clk, reset      : clock, async active-high reset
//   i_clear         : restarts the byte count at byte 0
//   i_valid, i_data : incoming byte
//   o_word_valid    : combinational, high while the 4th byte of a group is presented
//   o_word          : packed word, valid with o_word_valid
module imem_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_word_valid,
  output logic [31:0] o_word
);
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_valid) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= {i_data, r_word[31:8]};
    end
  end
  // bytes shift in from the top, so after three bytes r_word[31:8] holds {b2,b1,b0}
  assign o_word_valid = i_valid && r_cnt == 2'd3;
  assign o_word       = {i_data, r_word[31:8]};
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader writing a UART byte image (length word + data words) into instruction memory
//   clk, reset : clock, async active-high reset
//   bus        : imem_loader_if.master (restart, rx byte stream, memory write port, hold/select, status)
//   Optional checksum word after the data: define IMEM_LOADER_CHECKSUM_EN
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS
) (
  input  logic             clk,
  input  logic             reset,
  imem_loader_if.master    bus
);
  localparam int WL = $clog2(DEPTH_WORDS) + 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t W_TAIL = LOAD_SUM;
`else
  localparam loader_state_t W_TAIL = DONE;
`endif
  loader_state_t         r_state, w_next;
  logic [31:0]           r_n, r_idx;
  logic                  r_we, r_sel, r_hold, r_done, r_err;
  logic [XLEN_WIDTH-1:0] r_addr, r_wdata;
  logic [WL-1:0]         r_cnt;
  logic                  w_wv, w_clear;
  logic [31:0]           w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]           r_sum;
`endif
  imem_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_clear),
    .i_valid      (bus.rx_valid && r_state != DONE),
    .i_data       (bus.rx_data),
    .o_word_valid (w_wv),
    .o_word       (w_word)
  );
  always_comb begin
    w_next = r_state;
    if (bus.restart) w_next = LOAD_LEN;
    else if (w_wv) begin
      case (r_state)
        LOAD_LEN:  w_next = w_word == 32'd0 ? W_TAIL : LOAD_DATA;
        LOAD_DATA: w_next = r_idx == r_n - 32'd1 ? W_TAIL : LOAD_DATA;
        LOAD_SUM:  w_next = DONE;
        default:   w_next = r_state;
      endcase
    end
  end
  // the byte counter restarts on every state entry and on restart
  assign w_clear = bus.restart || w_next != r_state;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LOAD_LEN;
      r_n     <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= 1'b1;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_we    <= 1'b0;
      if (bus.restart) begin
        r_idx  <= '0;
        r_cnt  <= '0;
        r_done <= 1'b0;
        r_err  <= 1'b0;
        r_sel  <= 1'b1;
        r_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum  <= '0;
`endif
      end else if (r_state == DONE) begin
        // release lands one edge after DONE entry, i.e. after the final write pulse
        r_sel  <= 1'b0;
        r_hold <= 1'b0;
        r_done <= 1'b1;
      end else if (w_wv) begin
        if (r_state == LOAD_LEN) begin
          r_n   <= w_word;
          r_idx <= '0;
          if (w_word > 32'(DEPTH_WORDS)) r_err <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_sum <= '0;
`endif
        end else if (r_state == LOAD_DATA) begin
          r_idx <= r_idx + 32'd1;
          if (r_idx < 32'(DEPTH_WORDS)) begin
            r_we    <= 1'b1;
            r_addr  <= {r_idx[29:0], 2'b00};
            r_wdata <= w_word;
            r_cnt   <= r_cnt + WL'(1);
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_sum <= r_sum + w_word;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        else if (r_state == LOAD_SUM && w_word != r_sum) r_err <= 1'b1;
`endif
      end
    end
  end
  assign bus.mem_we       = r_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.mem_sel      = r_sel;
  assign bus.cpu_hold     = r_hold;
  assign bus.load_done    = r_done;
  assign bus.load_error   = r_err;
  assign bus.words_loaded = r_cnt;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader (write port checked against expected queue)
module tb_imem_loader;
  import imem_loader_pkg::*;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  imem_loader_if #(.DEPTH_WORDS(256)) bus ();
  imem_loader #(.DEPTH_WORDS(256)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  int n_chk = 0;
  int n_fail = 0;
  int n_we = 0;
  int base;
  int unsigned widx;
  logic [31:0] sum;
  logic [63:0] sb[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && bus.mem_we === 1'b1) begin
      n_we++;
      if (sb.size() == 0) chk("unexpected_write_count", 32'(sb.size()), 32'd1);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("wr_addr", bus.mem_addr, e[63:32]);
        chk("wr_data", bus.mem_wdata, e[31:0]);
      end
    end
  end
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask
  task automatic send_len(input logic [31:0] n);
    sum  = '0;
    widx = 0;
    send_word(n);
  endtask
  task automatic send_data(input logic [31:0] w);
    if (widx < 256) sb.push_back({32'(widx * 4), w});
    widx++;
    sum = sum + w;
    send_word(w);
  endtask
  task automatic finish_image;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(sum);
`endif
  endtask
  task automatic pulse_restart;
    @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.restart  = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hold", 32'(bus.cpu_hold), 32'd1);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_sel", 32'(bus.mem_sel), 32'd1);
    chk("idle_hold", 32'(bus.cpu_hold), 32'd1);
    chk("idle_we", 32'(bus.mem_we), 32'd0);
    chk("idle_done", 32'(bus.load_done), 32'd0);
    chk("idle_err", 32'(bus.load_error), 32'd0);
    chk("idle_words", 32'(bus.words_loaded), 32'd0);
    chk("idle_addr", bus.mem_addr, 32'd0);
    chk("idle_wdata", bus.mem_wdata, 32'd0);
    base = n_we;
    send_len(32'd2);
    send_data(32'h0000_0013);
    send_data(32'h0000_006F);
    chk("img2_hold_before", 32'(bus.cpu_hold), 32'd1);
    finish_image();
    @(negedge clk);
    chk("img2_we_pulse", 32'(bus.mem_we), 32'd0);
    chk("img2_hold", 32'(bus.cpu_hold), 32'd0);
    chk("img2_sel", 32'(bus.mem_sel), 32'd0);
    chk("img2_done", 32'(bus.load_done), 32'd1);
    chk("img2_words", 32'(bus.words_loaded), 32'd2);
    chk("img2_wr_count", 32'(n_we - base), 32'd2);
    pulse_restart();
    chk("rs_hold", 32'(bus.cpu_hold), 32'd1);
    chk("rs_sel", 32'(bus.mem_sel), 32'd1);
    chk("rs_done", 32'(bus.load_done), 32'd0);
    chk("rs_words", 32'(bus.words_loaded), 32'd0);
    base = n_we;
    send_len(32'd0);
    finish_image();
    @(negedge clk);
    chk("len0_done", 32'(bus.load_done), 32'd1);
    chk("len0_hold", 32'(bus.cpu_hold), 32'd0);
    chk("len0_words", 32'(bus.words_loaded), 32'd0);
    chk("len0_wr_count", 32'(n_we - base), 32'd0);
    pulse_restart();
    base = n_we;
    send_len(32'd257);
    chk("ovf_err_early", 32'(bus.load_error), 32'd1);
    for (int i = 0; i < 257; i++) send_data($urandom);
    finish_image();
    @(negedge clk);
    chk("ovf_words", 32'(bus.words_loaded), 32'd256);
    chk("ovf_wr_count", 32'(n_we - base), 32'd256);
    chk("ovf_done", 32'(bus.load_done), 32'd1);
    chk("ovf_hold", 32'(bus.cpu_hold), 32'd0);
    chk("ovf_err", 32'(bus.load_error), 32'd1);
    send_word(32'h0102_0304);
    repeat (2) @(negedge clk);
    chk("done_ignore_words", 32'(bus.words_loaded), 32'd256);
    chk("done_ignore_done", 32'(bus.load_done), 32'd1);
    pulse_restart();
    chk("rs_err_clear", 32'(bus.load_error), 32'd0);
    send_len(32'd2);
    send_data(32'h1111_1111);
    send_byte(8'h22);
    send_byte(8'h22);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h22;
    bus.restart  = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.restart  = 1'b0;
    chk("rsb_state", 32'(dut.r_state), 32'(LOAD_LEN));
    chk("rsb_hold", 32'(bus.cpu_hold), 32'd1);
    chk("rsb_words", 32'(bus.words_loaded), 32'd0);
    chk("rsb_err", 32'(bus.load_error), 32'd0);
    send_len(32'd1);
    send_data(32'hDEAD_BEEF);
    finish_image();
    @(negedge clk);
    chk("rsb_img_done", 32'(bus.load_done), 32'd1);
    chk("rsb_img_words", 32'(bus.words_loaded), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_restart();
    send_len(32'd2);
    send_data(32'd1);
    send_data(32'd2);
    send_word(32'd3);
    @(negedge clk);
    chk("cks_ok_err", 32'(bus.load_error), 32'd0);
    chk("cks_ok_hold", 32'(bus.cpu_hold), 32'd0);
    chk("cks_ok_done", 32'(bus.load_done), 32'd1);
    pulse_restart();
    send_len(32'd2);
    send_data(32'd1);
    send_data(32'd2);
    send_word(32'd4);
    @(negedge clk);
    chk("cks_bad_err", 32'(bus.load_error), 32'd1);
    chk("cks_bad_hold", 32'(bus.cpu_hold), 32'd0);
    chk("cks_bad_done", 32'(bus.load_done), 32'd1);
`endif
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
